// File: rtl/rope_renderer.sv
`default_nettype none
// ============================================================================
// Module      : rope_renderer
// Description : Rasterizes the rope node chain into framebuffer pixel writes.
//               On a frame request the packed node coordinate buses are
//               snapshotted, then the NODE_COUNT-1 segments between
//               consecutive nodes are walked with integer Bresenham. Every
//               on-screen point is offered on a valid/ready write port;
//               off-screen points are skipped at one per cycle.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               nodes_x, nodes_y    - packed 10-bit node coordinates
//               frame_start         - draw request (sampled only when idle)
//               pix_x, pix_y        - pixel write coordinates
//               pix_valid/pix_ready - write handshake
//               busy                - high whenever not idle
//               done                - one-cycle pulse at end of frame
// Revision    : 1.0 - initial release
// ============================================================================
module rope_renderer #(
    parameter int NODE_COUNT = 20,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NODE_COUNT*10-1:0]   nodes_x,
    input  logic [NODE_COUNT*10-1:0]   nodes_y,
    input  logic                       frame_start,
    output logic [9:0]                 pix_x,
    output logic [9:0]                 pix_y,
    output logic                       pix_valid,
    input  logic                       pix_ready,
    output logic                       busy,
    output logic                       done
);

    localparam int SEG_W = $clog2(NODE_COUNT);

    localparam logic [SEG_W-1:0] c_last_seg = SEG_W'(NODE_COUNT - 2);
    localparam logic [10:0]      c_screen_w = 11'(SCREEN_W);
    localparam logic [10:0]      c_screen_h = 11'(SCREEN_H);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEG_INIT = 2'd1,
        ST_DRAW     = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t                    r_state;
    logic [NODE_COUNT*10-1:0]  r_snap_x;
    logic [NODE_COUNT*10-1:0]  r_snap_y;
    logic [SEG_W-1:0]          r_seg;
    logic [9:0]                r_x;
    logic [9:0]                r_y;
    logic [9:0]                r_x1;
    logic [9:0]                r_y1;
    logic signed [11:0]        r_dx;
    logic signed [11:0]        r_dy;
    logic signed [11:0]        r_err;
    logic                      r_sx_neg;
    logic                      r_sy_neg;
    logic                      r_pix_valid;
    logic [9:0]                r_pix_x;
    logic [9:0]                r_pix_y;
    logic                      r_busy;
    logic                      r_done;

    // ------------------------------------------------------------------
    // Snapshot unpacking into per-node arrays
    // ------------------------------------------------------------------
    logic [9:0] w_node_x [NODE_COUNT];
    logic [9:0] w_node_y [NODE_COUNT];

    for (genvar k = 0; k < NODE_COUNT; k++) begin : g_unpack
        assign w_node_x[k] = r_snap_x[k*10 +: 10];
        assign w_node_y[k] = r_snap_y[k*10 +: 10];
    end

    // ------------------------------------------------------------------
    // Segment setup terms (used in SEG_INIT)
    // ------------------------------------------------------------------
    logic [SEG_W-1:0]   w_seg_next;
    logic [9:0]         w_sx0, w_sy0, w_sx1, w_sy1;
    logic [9:0]         w_adx, w_ady;
    logic signed [11:0] w_dx_init, w_dy_init;
    logic               w_init_on;

    assign w_seg_next = r_seg + 1'b1;
    assign w_sx0      = w_node_x[r_seg];
    assign w_sy0      = w_node_y[r_seg];
    assign w_sx1      = w_node_x[w_seg_next];
    assign w_sy1      = w_node_y[w_seg_next];
    assign w_adx      = (w_sx0 < w_sx1) ? (w_sx1 - w_sx0) : (w_sx0 - w_sx1);
    assign w_ady      = (w_sy0 < w_sy1) ? (w_sy1 - w_sy0) : (w_sy0 - w_sy1);
    assign w_dx_init  = $signed({2'b00, w_adx});
    assign w_dy_init  = -$signed({2'b00, w_ady});
    assign w_init_on  = ({1'b0, w_sx0} < c_screen_w) && ({1'b0, w_sy0} < c_screen_h);

    // ------------------------------------------------------------------
    // Bresenham step (used in DRAW)
    // ------------------------------------------------------------------
    logic signed [12:0] w_e2, w_dx13, w_dy13;
    logic               w_step_x, w_step_y;
    logic signed [11:0] w_err_next;
    logic [9:0]         w_x_next, w_y_next;
    logic               w_next_on;
    logic               w_at_end;
    logic               w_advance;

    // 2*err by shifting in a zero; 13 bits keep the full range of 2*err.
    assign w_e2       = {r_err, 1'b0};
    assign w_dx13     = {r_dx[11], r_dx};
    assign w_dy13     = {r_dy[11], r_dy};
    assign w_step_x   = (w_e2 >= w_dy13);
    assign w_step_y   = (w_e2 <= w_dx13);
    assign w_err_next = r_err + (w_step_x ? r_dy : 12'sd0) + (w_step_y ? r_dx : 12'sd0);
    assign w_x_next   = !w_step_x ? r_x : (r_sx_neg ? r_x - 10'd1 : r_x + 10'd1);
    assign w_y_next   = !w_step_y ? r_y : (r_sy_neg ? r_y - 10'd1 : r_y + 10'd1);
    assign w_next_on  = ({1'b0, w_x_next} < c_screen_w) && ({1'b0, w_y_next} < c_screen_h);
    assign w_at_end   = (r_x == r_x1) && (r_y == r_y1);

    // In DRAW the registered valid mirrors the on-screen test of the current
    // point, so a clipped point (valid low) advances without a handshake.
    assign w_advance  = !r_pix_valid || pix_ready;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_seg       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_err       <= '0;
            r_sx_neg    <= 1'b0;
            r_sy_neg    <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (frame_start) begin
                        r_snap_x <= nodes_x;
                        r_snap_y <= nodes_y;
                        r_seg    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SEG_INIT;
                    end
                end

                ST_SEG_INIT: begin
                    r_x         <= w_sx0;
                    r_y         <= w_sy0;
                    r_x1        <= w_sx1;
                    r_y1        <= w_sy1;
                    r_dx        <= w_dx_init;
                    r_dy        <= w_dy_init;
                    r_err       <= w_dx_init + w_dy_init;
                    r_sx_neg    <= !(w_sx0 < w_sx1);
                    r_sy_neg    <= !(w_sy0 < w_sy1);
                    r_pix_x     <= w_sx0;
                    r_pix_y     <= w_sy0;
                    r_pix_valid <= w_init_on;
                    r_state     <= ST_DRAW;
                end

                ST_DRAW: begin
                    if (w_advance) begin
                        if (w_at_end) begin
                            r_pix_valid <= 1'b0;
                            if (r_seg == c_last_seg) begin
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end else begin
                                r_seg   <= w_seg_next;
                                r_state <= ST_SEG_INIT;
                            end
                        end else begin
                            r_x         <= w_x_next;
                            r_y         <= w_y_next;
                            r_err       <= w_err_next;
                            r_pix_x     <= w_x_next;
                            r_pix_y     <= w_y_next;
                            r_pix_valid <= w_next_on;
                        end
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign pix_valid = r_pix_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rope_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rope_renderer
// Description : Self-checking bench for rope_renderer. Pixel streams are
//               compared against a Bresenham reference computed with plain
//               integer arithmetic from the node arrays.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rope_renderer;

    localparam int NC = 20;
    localparam int W  = 640;
    localparam int H  = 480;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC*10-1:0]  nodes_x;
    logic [NC*10-1:0]  nodes_y;
    logic              frame_start;
    logic [9:0]        pix_x;
    logic [9:0]        pix_y;
    logic              pix_valid;
    logic              pix_ready;
    logic              busy;
    logic              done;

    rope_renderer #(
        .NODE_COUNT (NC),
        .SCREEN_W   (W),
        .SCREEN_H   (H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .nodes_x     (nodes_x),
        .nodes_y     (nodes_y),
        .frame_start (frame_start),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int          mx [NC];
    int          my [NC];
    logic [19:0] got_q [$];
    logic [19:0] exp_q [$];

    int first_valid_cyc;
    int last_acc_cyc;
    int done_cyc;
    int done_cnt;
    int stall_bad;
    int timed_out;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic load_nodes();
        for (int k = 0; k < NC; k++) begin
            nodes_x[k*10 +: 10] = 10'(mx[k]);
            nodes_y[k*10 +: 10] = 10'(my[k]);
        end
    endtask

    // Reference rasterizer: integer Bresenham per segment, clip by screen.
    function automatic void build_model();
        int x, y, x1, y1, dx, dy, sx, sy, err, e2;
        exp_q.delete();
        for (int s = 0; s < NC - 1; s++) begin
            x  = mx[s];   y  = my[s];
            x1 = mx[s+1]; y1 = my[s+1];
            dx = (x1 > x) ? x1 - x : x - x1;
            dy = -((y1 > y) ? y1 - y : y - y1);
            sx = (x < x1) ? 1 : -1;
            sy = (y < y1) ? 1 : -1;
            err = dx + dy;
            while (1) begin
                if (x < W && y < H) exp_q.push_back({10'(x), 10'(y)});
                if (x == x1 && y == y1) break;
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x += sx; end
                if (e2 <= dx) begin err += dx; y += sy; end
            end
        end
    endfunction

    // Issues one frame_start pulse and records accepted writes until the
    // frame ends. mode: 0 ready high, 1 ready pattern 1,0,0, 2 random.
    // poke_cyc: cycle at which nodes_x is scrambled and frame_start pulsed.
    task automatic run_frame(input int mode, input int poke_cyc, input int max_cyc);
        logic       prev_v;
        logic       prev_r;
        logic [9:0] prev_x;
        logic [9:0] prev_y;
        got_q.delete();
        first_valid_cyc = -1;
        last_acc_cyc    = -1;
        done_cyc        = -1;
        done_cnt        = 0;
        stall_bad       = 0;
        timed_out       = 1;
        @(negedge clk);
        frame_start = 1'b1;
        pix_ready   = 1'b1;
        prev_v = 1'b0; prev_r = 1'b1; prev_x = '0; prev_y = '0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(negedge clk);
            frame_start = (cyc == poke_cyc);
            if (cyc == poke_cyc)
                for (int k = 0; k < NC; k++) nodes_x[k*10 +: 10] = 10'($urandom_range(0, 639));
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = (cyc % 3 == 1);
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_v && !prev_r && (!pix_valid || pix_x != prev_x || pix_y != prev_y))
                stall_bad++;
            if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pix_valid && pix_ready) begin
                got_q.push_back({pix_x, pix_y});
                last_acc_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            prev_v = pix_valid; prev_r = pix_ready; prev_x = pix_x; prev_y = pix_y;
            if (done_cyc >= 0 && !busy) begin
                timed_out = 0;
                break;
            end
        end
        frame_start = 1'b0;
        pix_ready   = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_start = 1'b0; pix_ready = 1'b0;
        nodes_x = '0; nodes_y = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); end
        n_cmp++; if (pix_x !== 10'd0) begin n_err++; $display("FAIL reset_pix_x: got %0d expected 0", pix_x); end
        n_cmp++; if (pix_y !== 10'd0) begin n_err++; $display("FAIL reset_pix_y: got %0d expected 0", pix_y); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        reset = 1'b0;
        pix_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_degenerate();
        int bad;
        for (int k = 0; k < NC; k++) begin mx[k] = 5; my[k] = 7; end
        load_nodes();
        run_frame(0, -1, 500);
        bad = 0;
        foreach (got_q[i]) if (got_q[i] != {10'd5, 10'd7}) bad++;
        n_cmp++; if (timed_out != 0) begin n_err++; $display("FAIL degen_timeout: got %0d expected 0", timed_out); end
        n_cmp++; if (got_q.size() != NC - 1) begin n_err++; $display("FAIL degen_count: got %0d expected %0d", got_q.size(), NC - 1); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL degen_coord: got %0d bad writes expected 0", bad); end
        n_cmp++; if (first_valid_cyc != 2) begin n_err++; $display("FAIL degen_latency: got %0d expected 2", first_valid_cyc); end
        // one point per segment plus one setup bubble per segment
        n_cmp++; if (last_acc_cyc != 2 + 2 * (NC - 2)) begin n_err++; $display("FAIL degen_last: got %0d expected %0d", last_acc_cyc, 2 + 2 * (NC - 2)); end
        n_cmp++; if (done_cyc != last_acc_cyc + 1) begin n_err++; $display("FAIL degen_done_time: got %0d expected %0d", done_cyc, last_acc_cyc + 1); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL degen_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic check_horizontal_list(input string tag);
        logic [19:0] ref_q [$];
        for (int x = 10; x <= 14; x++) ref_q.push_back({10'(x), 10'd20});
        for (int k = 0; k < 18; k++) ref_q.push_back({10'd14, 10'd20});
        n_cmp++; if (got_q.size() != 23) begin n_err++; $display("FAIL %s_count: got %0d expected 23", tag, got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 23; i++) begin
            n_cmp++;
            if (got_q[i] !== ref_q[i]) begin
                n_err++;
                $display("FAIL %s_pix[%0d]: got (%0d,%0d) expected (%0d,%0d)", tag, i,
                         got_q[i][19:10], got_q[i][9:0], ref_q[i][19:10], ref_q[i][9:0]);
            end
        end
    endtask

    task automatic test_horizontal();
        mx[0] = 10; my[0] = 20;
        for (int k = 1; k < NC; k++) begin mx[k] = 14; my[k] = 20; end
        load_nodes();
        run_frame(0, -1, 500);
        check_horizontal_list("horiz");
        // 5 back-to-back points, then one bubble + one point per segment
        n_cmp++; if (last_acc_cyc != 6 + 2 * (NC - 2)) begin n_err++; $display("FAIL horiz_last: got %0d expected %0d", last_acc_cyc, 6 + 2 * (NC - 2)); end
        n_cmp++; if (done_cyc != last_acc_cyc + 1) begin n_err++; $display("FAIL horiz_done_time: got %0d expected %0d", done_cyc, last_acc_cyc + 1); end
    endtask

    task automatic test_backpressure();
        mx[0] = 10; my[0] = 20;
        for (int k = 1; k < NC; k++) begin mx[k] = 14; my[k] = 20; end
        load_nodes();
        run_frame(1, -1, 1000);
        check_horizontal_list("bp");
        n_cmp++; if (stall_bad != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_bad); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_steep();
        int bad;
        mx[0] = 8; my[0] = 8;
        for (int k = 1; k < NC; k++) begin mx[k] = 6; my[k] = 2; end
        load_nodes();
        build_model();
        run_frame(0, -1, 500);
        n_cmp++; if (got_q.size() != 7 + NC - 2) begin n_err++; $display("FAIL steep_count: got %0d expected %0d", got_q.size(), 7 + NC - 2); end
        bad = 0;
        for (int i = 0; i < 7 && i < got_q.size(); i++) begin
            if (got_q[i][9:0] != 10'(8 - i)) bad++;
            if (got_q[i][19:10] < 10'd6 || got_q[i][19:10] > 10'd8) bad++;
            if (i > 0 && got_q[i][19:10] > got_q[i-1][19:10]) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL steep_shape: got %0d violations expected 0", bad); end
        n_cmp++; if (got_q.size() < 7 || got_q[6] != {10'd6, 10'd2}) begin n_err++; $display("FAIL steep_end: got size %0d expected endpoint (6,2) at index 6", got_q.size()); end
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL steep_model_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL steep_pix[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_clip();
        int bad;
        mx[0] = 630; my[0] = 100;
        for (int k = 1; k < NC; k++) begin mx[k] = 650; my[k] = 100; end
        load_nodes();
        run_frame(0, -1, 500);
        n_cmp++; if (got_q.size() != 10) begin n_err++; $display("FAIL clip_count: got %0d expected 10", got_q.size()); end
        bad = 0;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] != {10'(630 + i), 10'd100}) bad++;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL clip_coord: got %0d bad writes expected 0", bad); end
        n_cmp++; if (done_cnt != 1 || timed_out != 0) begin n_err++; $display("FAIL clip_done: got done_cnt %0d timeout %0d expected 1/0", done_cnt, timed_out); end
    endtask

    task automatic test_snapshot();
        int late;
        for (int k = 0; k < NC; k++) begin mx[k] = 100 + 3 * k; my[k] = 200 - 2 * k; end
        load_nodes();
        build_model();
        run_frame(0, 5, 1000);
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL snap_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL snap_pix[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL snap_done_count: got %0d expected 1", done_cnt); end
        late = 0;
        repeat (5) begin @(negedge clk); if (busy || pix_valid) late++; end
        n_cmp++; if (late != 0) begin n_err++; $display("FAIL snap_no_requeue: got %0d busy cycles expected 0", late); end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        mx[0] = 0; my[0] = 50;
        for (int k = 1; k < NC; k++) begin mx[k] = 300; my[k] = 50; end
        load_nodes();
        @(negedge clk); frame_start = 1'b1; pix_ready = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (pix_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_drawing: got %b expected 1", pix_valid); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", pix_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        done_seen = done ? 1 : 0;
        reset = 1'b0;
        repeat (5) begin @(negedge clk); if (done) done_seen++; end
        n_cmp++; if (done_seen != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_seen); end
        build_model();
        run_frame(0, -1, 2000);
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rstmid_refill_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL rstmid_refill_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            mx[0] = int'($urandom_range(0, 700));
            my[0] = int'($urandom_range(0, 520));
            for (int k = 1; k < NC; k++) begin
                mx[k] = mx[k-1] + int'($urandom_range(0, 60)) - 30;
                my[k] = my[k-1] + int'($urandom_range(0, 60)) - 30;
                if (mx[k] < 0) mx[k] = 0;
                if (my[k] < 0) my[k] = 0;
                if (mx[k] > 1023) mx[k] = 1023;
                if (my[k] > 1023) my[k] = 1023;
            end
            load_nodes();
            build_model();
            run_frame(2, -1, 6000);
            n_cmp++; if (timed_out != 0) begin n_err++; $display("FAIL rand%0d_timeout: got %0d expected 0", f, timed_out); end
            n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand%0d_count: got %0d expected %0d", f, got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_pix[%0d]: got %h expected %h", f, i, got_q[i], exp_q[i]); end
            end
            n_cmp++; if (stall_bad != 0) begin n_err++; $display("FAIL rand%0d_stable: got %0d expected 0", f, stall_bad); end
            n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL rand%0d_done: got %0d expected 1", f, done_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_degenerate();
        test_horizontal();
        test_backpressure();
        test_steep();
        test_clip();
        test_snapshot();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
